fnd_clock_display: RTL and testbench

- Downstream consumer of the clock block's time outputs (msec/sec/min/hour, set-field code, msec tick).
- Drives the Basys3 4-digit 7-segment display.
- Time-multiplexes the four digits at a fixed scan rate and converts binary fields to decimal digits.
- Blinks the field currently being edited and flashes the colon dot once per second.

---
 rtl/fnd_clock_display.sv | 153 +++++++++++++++
 tb/tb_fnd_clock_display.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fnd_clock_display.sv
// Basys3 4-digit 7-segment driver for the clock block: scans the digits, converts the time fields
// to decimal, blinks the field being edited and flashes the colon dot once per second.
module fnd_clock_display #(
  parameter int unsigned P_SCAN_DIV    = 100000,
  parameter int unsigned P_BLINK_TICKS = 25
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iMode,
  input  logic [1:0] iSet,
  input  logic [6:0] iMsec,
  input  logic [5:0] iSec,
  input  logic [5:0] iMin,
  input  logic [4:0] iHour,
  input  logic       iMsec_Tick,
  output logic [3:0] oFnd_Com,
  output logic [7:0] oFnd_Data
);

  localparam int unsigned PresWidth  = (P_SCAN_DIV > 2) ? $clog2(P_SCAN_DIV) : 1;
  localparam int unsigned BlinkWidth = (P_BLINK_TICKS > 2) ? $clog2(P_BLINK_TICKS) : 1;
  localparam logic [PresWidth-1:0]  PresLast  = PresWidth'(P_SCAN_DIV - 1);
  localparam logic [BlinkWidth-1:0] BlinkLast = BlinkWidth'(P_BLINK_TICKS - 1);

  logic [PresWidth-1:0]  presc_q, presc_d;
  logic [1:0]            idx_q, idx_d;
  logic                  upd_q, upd_d;
  logic [BlinkWidth-1:0] blink_cnt_q, blink_cnt_d;
  logic                  phase_q, phase_d;
  logic [6:0]            snap_msec_q, snap_msec_d;
  logic [5:0]            snap_sec_q, snap_sec_d;
  logic [5:0]            snap_min_q, snap_min_d;
  logic [4:0]            snap_hour_q, snap_hour_d;
  logic                  snap_mode_q, snap_mode_d;
  logic [3:0]            com_q, com_d;
  logic [7:0]            data_q, data_d;

  logic       strobe;
  logic [6:0] field_val;
  logic [3:0] digit;
  logic [7:0] seg;
  logic       dp;
  logic       blank;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Scan prescaler, digit index and frame-boundary snapshot.
  always_comb begin
    strobe      = (presc_q == PresLast);
    presc_d     = strobe ? '0 : presc_q + 1'b1;
    idx_d       = strobe ? idx_q + 2'd1 : idx_q;
    upd_d       = strobe;
    snap_msec_d = snap_msec_q;
    snap_sec_d  = snap_sec_q;
    snap_min_d  = snap_min_q;
    snap_hour_d = snap_hour_q;
    snap_mode_d = snap_mode_q;
    if (strobe && idx_q == 2'd3) begin
      snap_msec_d = iMsec;
      snap_sec_d  = iSec;
      snap_min_d  = iMin;
      snap_hour_d = iHour;
      snap_mode_d = iMode;
    end
  end

  // Blink timing; leaving iSet at zero parks the phase in the visible state.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (iSet == 2'b00) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (iMsec_Tick) begin
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Digit content for the current index; idx[1] picks the left field, idx[0] the tens digit.
  always_comb begin
    if (snap_mode_q) begin
      field_val = idx_q[1] ? {1'b0, snap_sec_q} : snap_msec_q;
    end else begin
      field_val = idx_q[1] ? {2'b00, snap_hour_q} : {1'b0, snap_min_q};
    end
    if (field_val > 7'd99) field_val = 7'd99;
    digit = idx_q[0] ? 4'(field_val / 7'd10) : 4'(field_val % 7'd10);
    seg   = seg_code(digit);
    dp    = (idx_q == 2'd2) && (snap_mode_q || (snap_msec_q < 7'd50));
    blank = !snap_mode_q && !phase_q &&
            ((iSet[1] && idx_q[1]) || (iSet == 2'b01 && !idx_q[1]));
    com_d  = ~(4'b0001 << idx_q);
    data_d = {~dp, blank ? 7'h7F : seg[6:0]};
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      presc_q     <= '0;
      idx_q       <= 2'd0;
      upd_q       <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      snap_msec_q <= '0;
      snap_sec_q  <= '0;
      snap_min_q  <= '0;
      snap_hour_q <= '0;
      snap_mode_q <= 1'b0;
      com_q       <= 4'b1111;
      data_q      <= 8'hFF;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      upd_q       <= upd_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      snap_msec_q <= snap_msec_d;
      snap_sec_q  <= snap_sec_d;
      snap_min_q  <= snap_min_d;
      snap_hour_q <= snap_hour_d;
      snap_mode_q <= snap_mode_d;
      // Outputs follow the index one cycle late so they stay dark until the first strobe.
      if (upd_q) begin
        com_q  <= com_d;
        data_q <= data_d;
      end
    end
  end

  assign oFnd_Com  = com_q;
  assign oFnd_Data = data_q;

endmodule

// File: tb/tb_fnd_clock_display.sv
// Directed bench for fnd_clock_display with a 4-cycle scan slot and 2-tick blink half-period.
module tb_fnd_clock_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic [1:0] set;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       tick;
  logic [3:0] com;
  logic [7:0] data;

  int n_tests = 0;
  int n_fail  = 0;

  fnd_clock_display #(
    .P_SCAN_DIV   (4),
    .P_BLINK_TICKS(2)
  ) dut (
    .iClk      (clk),
    .iRst      (rst_n),
    .iMode     (mode),
    .iSet      (set),
    .iMsec     (msec),
    .iSec      (sec),
    .iMin      (min),
    .iHour     (hour),
    .iMsec_Tick(tick),
    .oFnd_Com  (com),
    .oFnd_Data (data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for a fresh registration of digit d (the enable must leave and return).
  task automatic wait_digit(input int d);
    logic [3:0] target;
    bit         found;
    target = ~(4'b0001 << d);
    found  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (com != target) break;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (com == target) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check($sformatf("timeout_idx%0d", d), {31'd0, found}, 32'd1);
  endtask

  task automatic new_frame();
    wait_digit(3);
    wait_digit(0);
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    mode  = 1'b0;
    set   = 2'b00;
    msec  = '0;
    sec   = '0;
    min   = '0;
    hour  = '0;
    tick  = 1'b0;

    // 1: reset and scan order
    repeat (3) @(negedge clk);
    check("rst_com", {28'd0, com}, 32'hF);
    check("rst_data", {24'd0, data}, 32'hFF);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("pre_strobe_com_%0d", i), {28'd0, com}, 32'hF);
      check($sformatf("pre_strobe_data_%0d", i), {24'd0, data}, 32'hFF);
    end
    @(negedge clk);
    check("first_com_idx1", {28'd0, com}, 32'hD);
    check("first_data_idx1", {24'd0, data}, 32'hC0);
    repeat (4) @(negedge clk);
    check("scan_com_idx2", {28'd0, com}, 32'hB);
    check("scan_data_idx2", {24'd0, data}, 32'h40);
    repeat (4) @(negedge clk);
    check("scan_com_idx3", {28'd0, com}, 32'h7);
    repeat (4) @(negedge clk);
    check("scan_com_idx0", {28'd0, com}, 32'hE);

    // 2: HH.MM view 13:07, msec 20 lights the dot
    hour = 5'd13;
    min  = 6'd7;
    msec = 7'd20;
    new_frame();
    check("m0_idx0", {24'd0, data}, 32'hF8);
    wait_digit(1);
    check("m0_idx1", {24'd0, data}, 32'hC0);
    wait_digit(2);
    check("m0_idx2", {24'd0, data}, 32'h30);
    wait_digit(3);
    check("m0_idx3", {24'd0, data}, 32'hF9);

    // 3: SS.cc view, then saturation of msec
    mode = 1'b1;
    sec  = 6'd45;
    msec = 7'd99;
    new_frame();
    check("m1_idx0", {24'd0, data}, 32'h90);
    wait_digit(1);
    check("m1_idx1", {24'd0, data}, 32'h90);
    wait_digit(2);
    check("m1_idx2", {24'd0, data}, 32'h12);
    wait_digit(3);
    check("m1_idx3", {24'd0, data}, 32'h99);
    msec = 7'd127;
    new_frame();
    check("sat_idx0", {24'd0, data}, 32'h90);
    wait_digit(1);
    check("sat_idx1", {24'd0, data}, 32'h90);

    // 4: blink of the hour field, then minute field, then 2'b11 as hour
    mode = 1'b0;
    msec = 7'd20;
    set  = 2'b10;
    new_frame();
    pulse_tick();
    pulse_tick();
    wait_digit(3);
    check("blink_h_idx3", {24'd0, data}, 32'hFF);
    wait_digit(2);
    check("blink_h_idx2_dp", {24'd0, data}, 32'h7F);
    wait_digit(1);
    check("blink_h_idx1", {24'd0, data}, 32'hC0);
    wait_digit(0);
    check("blink_h_idx0", {24'd0, data}, 32'hF8);
    pulse_tick();
    pulse_tick();
    wait_digit(3);
    check("blink_h_back_idx3", {24'd0, data}, 32'hF9);
    wait_digit(2);
    check("blink_h_back_idx2", {24'd0, data}, 32'h30);
    pulse_tick();
    pulse_tick();
    wait_digit(3);
    check("blink_h_again_idx3", {24'd0, data}, 32'hFF);
    set = 2'b00;
    wait_digit(3);
    check("set_clear_idx3", {24'd0, data}, 32'hF9);
    set = 2'b01;
    pulse_tick();
    pulse_tick();
    wait_digit(1);
    check("blink_m_idx1", {24'd0, data}, 32'hFF);
    wait_digit(0);
    check("blink_m_idx0", {24'd0, data}, 32'hFF);
    wait_digit(3);
    check("blink_m_idx3", {24'd0, data}, 32'hF9);
    set = 2'b00;
    @(negedge clk);
    set = 2'b11;
    pulse_tick();
    pulse_tick();
    wait_digit(2);
    check("blink_11_idx2", {24'd0, data}, 32'h7F);
    set = 2'b00;

    // 5: minute change mid-frame waits for the wrap; msec 60 turns the dot off
    min  = 6'd59;
    msec = 7'd60;
    new_frame();
    check("snap_idx0_old", {24'd0, data}, 32'h90);
    wait_digit(1);
    check("snap_idx1_old", {24'd0, data}, 32'h92);
    min = 6'd0;
    @(negedge clk);
    check("snap_idx1_hold", {24'd0, data}, 32'h92);
    wait_digit(2);
    check("snap_idx2_nodp", {24'd0, data}, 32'hB0);
    wait_digit(0);
    check("snap_idx0_new", {24'd0, data}, 32'hC0);
    wait_digit(1);
    check("snap_idx1_new", {24'd0, data}, 32'hC0);

    // 6: asynchronous reset mid-frame
    wait_digit(2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_com", {28'd0, com}, 32'hF);
    check("async_rst_data", {24'd0, data}, 32'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_com_%0d", i), {28'd0, com}, 32'hF);
    end
    @(negedge clk);
    check("post_rst_first_com", {28'd0, com}, 32'hD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
